// File: rtl/bm_pkg.sv
// Shared Box-Muller datapath constants and the IEEE-754 double payload layout.
package bm_pkg;

  localparam int unsigned FP_W       = 64;
  localparam int unsigned FP_SIGN    = 63;
  localparam int unsigned FP_EXP_HI  = 62;
  localparam int unsigned FP_EXP_LO  = 52;
  localparam int unsigned FP_FRAC_HI = 51;
  localparam int unsigned FP_FRAC_LO = 0;
  localparam int unsigned FPMUL_LAT  = 12;
  localparam int unsigned DRAIN_DEPTH = 16;

  // Double-precision word as produced by fpmul.r
  typedef struct packed {
    logic        sign;
    logic [10:0] exp;
    logic [51:0] frac;
  } fp64_t;

  // True when v is a non-zero power of two
  function automatic logic is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fpmul_drain_if.sv
// Sequencer / multiplier / consumer side bundle of the fpmul drain buffer.
interface fpmul_drain_if #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
);

  logic          issue_req;
  logic          issue_ok;
  logic          mul_pushin;
  logic          mul_pushout;
  logic [W-1:0]  mul_r;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic          err;

  // Drain buffer side
  modport master (
    input  issue_req, mul_pushout, mul_r, out_ready,
    output issue_ok, mul_pushin, out_valid, out_data, count, inflight, err
  );

  // Environment side: sequencer, multiplier and consumer
  modport slave (
    output issue_req, mul_pushout, mul_r, out_ready,
    input  issue_ok, mul_pushin, out_valid, out_data, count, inflight, err
  );

endinterface

// File: rtl/bm_sync_fifo.sv
// Single-clock FIFO with occupancy counter; write-while-full is dropped and flagged.
module bm_sync_fifo
  import bm_pkg::*;
#(
  parameter int unsigned W     = FP_W,
  parameter int unsigned DEPTH = DRAIN_DEPTH,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          ovf
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ok_c;
  logic          rd_ok_c;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign rd_ok_c = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts then
  assign wr_ok_c = wr_en & (~full | rd_ok_c);
  assign ovf     = wr_en & full & ~rd_ok_c;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok_c) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_ok_c, rd_ok_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/fpmul_drain.sv
// Credit-gated result buffer behind the no-backpressure fpmul pipeline.
module fpmul_drain
  import bm_pkg::*;
#(
  parameter int unsigned W     = FP_W,
  parameter int unsigned DEPTH = DRAIN_DEPTH,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  fpmul_drain_if.master     bus
);

  localparam int unsigned RW = CW + 1;

  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("fpmul_drain: DEPTH must be a power of two and at least 2");
  end

  logic [CW-1:0] inflight_q, inflight_d;
  logic          err_q, err_d;
  logic [RW-1:0] resv_c;
  logic          issue_ok_c;
  logic          pushin_c;
  logic          pop_c;
  logic          ret_orphan_c;

  logic [W-1:0]  fifo_rd_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_ovf;

  // Result storage
  bm_sync_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.mul_pushout),
    .wr_data (bus.mul_r),
    .rd_en   (pop_c),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .ovf     (fifo_ovf)
  );

  // Every outstanding product already owns a FIFO slot, so credit comes from registers only
  assign resv_c       = RW'(fifo_count) + RW'(inflight_q);
  assign issue_ok_c   = (resv_c < RW'(DEPTH));
  assign pushin_c     = bus.issue_req & issue_ok_c;
  assign pop_c        = ~fifo_empty & bus.out_ready;
  assign ret_orphan_c = bus.mul_pushout & (inflight_q == '0);

  assign bus.issue_ok   = issue_ok_c;
  assign bus.mul_pushin = pushin_c;
  assign bus.out_valid  = ~fifo_empty;
  assign bus.out_data   = fifo_rd_data;
  assign bus.count      = fifo_count;
  assign bus.inflight   = inflight_q;
  assign bus.err        = err_q;

  // In-flight tracking and sticky protocol error
  always_comb begin
    inflight_d = inflight_q;
    err_d      = err_q | fifo_ovf | ret_orphan_c;
    if (pushin_c && !bus.mul_pushout) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!pushin_c && bus.mul_pushout && !ret_orphan_c) begin
      inflight_d = inflight_q - CW'(1);
    end
  end

  // Counter and error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: doc/fpmul_drain.md
# fpmul_drain

Credit-gated output buffer that sits directly downstream of the fixed-latency triple-product floating-point multiplier, `fpmul`. The multiplier has no backpressure: once `pushin` is taken, `r` appears with `pushout` a fixed number of cycles later. This block grants issue slots to the upstream sequencer only when a FIFO entry is guaranteed for the result, captures every `pushout`/`r` pair, and presents results to the Box-Muller consumer over a valid/ready handshake.

## Interface
- `DEPTH`, 16: FIFO entries; ≥ 2, power of two.
- `W`, 64: result width (sign, 11-bit exponent, 52-bit fraction).
- `CW`, $clog2(DEPTH+1): width of the occupancy and in-flight counters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `issue_req` in 1: sequencer has a valid a,b,c triple this cycle.
- `issue_ok` out 1: a credit is available.
- `mul_pushin` out 1: drives `fpmul.pushin`; equals `issue_req & issue_ok`.
- `mul_pushout` in 1: from `fpmul.pushout`.
- `mul_r` in W: from `fpmul.r`; sampled only when `mul_pushout`=1.
- `out_valid` out 1: FIFO non-empty.
- `out_data` out W: head entry; held stable while `out_valid & !out_ready`.
- `out_ready` in 1: consumer accepts the head this cycle.
- `count` out CW: FIFO occupancy.
- `inflight` out CW: products issued to the multiplier but not yet returned.
- `err` out 1: sticky protocol-error flag.

## Operation
- Reservation: `resv = count + inflight` (CW+1-bit sum). `issue_ok = (resv < DEPTH)`. This is combinational from registered state only, with no path from `out_ready` or `mul_pushout`.
- In-flight counter:
  - +1 on `mul_pushin` alone.
  - −1 on `mul_pushout` alone.
  - Unchanged when both occur.
- FIFO write: `mul_r` is written at `wr_ptr` when `mul_pushout`=1.
- FIFO read (pop): `out_valid & out_ready`; advances `rd_ptr`.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally.
- `count` update:
  - +1 on write only.
  - −1 on pop only.
  - Unchanged on simultaneous write and pop, including when full or when `count`=1.
- A credit freed by a pop is usable in the following cycle, not the same cycle.
- Error cases (either sets `err`, which holds until `rst`):
  - Write while `count==DEPTH` with no simultaneous pop: the data is dropped.
  - `mul_pushout` while `inflight==0`: `inflight` saturates at 0.
- Credit gating makes both error cases unreachable in correct operation. The bench asserts `err` stays 0.
- `mul_r` contents are not interpreted; zero results (all-zero word) pass through like any other value.
- Reset values: `count`=0, `inflight`=0, pointers=0, `err`=0, `out_valid`=0, `issue_ok`=1, `mul_pushin`=`issue_req`. `out_data` is don't-care while `out_valid`=0.
- Reset mid-operation: all state clears immediately. `fpmul` shares `rst`, so its pipeline also empties and no stale `pushout` arrives after reset.

## Timing
- Write at edge t (`mul_pushout`=1 in cycle t−1) → `out_valid`=1 in cycle t when the FIFO was empty. There is one cycle of buffer latency and no bypass.
- Issue-to-result latency is set by `fpmul` (12 cycles), not by this block. This block makes no assumption about its value.
- Throughput: one issue and one pop per cycle sustained when `DEPTH` ≥ multiplier latency + 2 and the consumer is always ready.
- `out_data`/`out_valid` depend on registers only. `issue_ok` depends on registers only.

## Structure
- Shared package `bm_pkg`: `FP_W`=64, field slices (`FP_SIGN`=63, `FP_EXP`=62:52, `FP_FRAC`=51:0), `FPMUL_LAT`=12.
- Sub-module `bm_sync_fifo` (W, DEPTH):
  - Holds the register array, pointers and `count`.
  - Ports: `wr_en`, `wr_data`, `rd_en`, `rd_data`, `count`, `full`, `empty`, `ovf`.
- Top level holds the in-flight counter, credit logic and `err`.

## Test plan
- Reset, idle: after `rst` deassert → `issue_ok`=1, `out_valid`=0, `count`=0, `inflight`=0, `err`=0.
- Single transaction:
  - `issue_req` pulse → `mul_pushin`=1, `inflight`=1.
  - Model returns `mul_r`=64'h4000_0000_0000_0000 12 cycles later → `out_valid`=1 next cycle with that data.
  - `out_ready`=1 → `count`=0 and `inflight`=0.
- Credit exhaustion:
  - Setup: `DEPTH`=16, `out_ready`=0, `issue_req` held high.
  - Exactly 16 issues, then `issue_ok`=0. After all returns, `count`=16, `out_valid` stays 1, `err`=0.
  - One pop → `issue_ok`=1 in the next cycle, not the same cycle.
- Simultaneous events:
  - Full FIFO, pop and write in the same cycle → `count` stays 16, data order preserved.
  - Issue and return in the same cycle → `inflight` unchanged.
- Pointer wrap: 40 back-to-back transactions with random `out_ready` (50%) → output sequence equals input sequence, no loss, `err`=0.
- Errors and reset:
  - Inject `mul_pushout` with `inflight`=0 → `err`=1 and sticky.
  - Assert `rst` mid-stream with `count`=5, `inflight`=7 → all counters 0, `err`=0, `out_valid`=0 asynchronously.
